s_box_layer_seq: RTL

- Iterative PRESENT S-box substitution layer for a full cipher state.
- Applies the 4-bit PRESENT S-box, or its inverse, to every nibble of a WIDTH-bit word.
- Processes LANES nibbles per clock, trading area against latency.
- Sits between the round-key XOR and the permutation layer in the datapath; uses a valid/ready handshake on both sides.

---
 rtl/s_box_layer_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/s_box_layer_seq.sv
// Iterative PRESENT S-box layer: substitutes LANES nibbles of a WIDTH-bit state
// per clock, forward or inverse, behind valid/ready handshakes on both sides.
`timescale 1ns/1ps

module s_box_layer_seq #(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             Clk_ik,
  input  logic             Reset_ir,
  input  logic [WIDTH-1:0] Data_ib,
  input  logic             Inverse_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  output logic [WIDTH-1:0] Data_ob,
  output logic             Valid_o,
  input  logic             Ready_i
);

  localparam int N     = WIDTH / 4;
  localparam int STEPS = (LANES > 0) ? N / LANES : 1;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject configurations that would leave a partial nibble or a ragged last step.
  if ((WIDTH < 4) || (WIDTH % 4 != 0)) begin : g_bad_width
    $error("s_box_layer_seq: WIDTH must be a positive multiple of 4");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("s_box_layer_seq: LANES must be at least 1");
  end else if (N % LANES != 0) begin : g_bad_split
    $error("s_box_layer_seq: WIDTH/4 must be divisible by LANES");
  end

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  logic [1:0]       state_q;
  logic [WIDTH-1:0] data_q;
  logic             inverse_q;
  logic [CNT_W-1:0] step_q;
  logic             last_step;

  logic [LANES-1:0][IDX_W-1:0] lane_idx;
  logic [LANES-1:0][3:0]       lane_out;

  assign last_step = (step_q == CNT_W'(STEPS - 1));

  // Only LANES S-box instances exist; each picks its nibble of the current step.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] lane_in;
    assign lane_idx[l] = IDX_W'((int'(step_q) * LANES + l) * 4);
    assign lane_in     = data_q[lane_idx[l] +: 4];
    assign lane_out[l] = inverse_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      // NOTE: the data register is reset too, because it drives Data_ob directly
      // and a defined zero output after reset is part of the interface contract.
      state_q   <= S_IDLE;
      data_q    <= '0;
      inverse_q <= 1'b0;
      step_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Valid_i) begin
            data_q    <= Data_ib;
            inverse_q <= Inverse_i;
            step_q    <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            data_q[lane_idx[l] +: 4] <= lane_out[l];
          end
          if (last_step) begin
            step_q  <= '0;
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (Ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only; no input reaches them combinationally.
  assign Ready_o = (state_q == S_IDLE);
  assign Valid_o = (state_q == S_DONE);
  assign Data_ob = data_q;

endmodule
